// File: rtl/priority_code_decoder.sv
// rtl/priority_code_decoder.sv - streaming priority-code decoder with output FIFO
module priority_code_decoder #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_code,
  input  logic                       in_pair,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_bits,
  output logic                       out_none,
  output logic [7:0]                 none_count,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [8:0]    mem [DEPTH];

  logic [7:0]    dec_bits;
  logic          dec_none;
  logic          push;
  logic          pop;
  logic [AW-1:0] rd_ptr_n;
  logic [LW-1:0] level_after_pop;
  logic [LW-1:0] level_n;
  logic [8:0]    head_n;

  // Handshake flags come only from registered occupancy; a full FIFO never
  // accepts even when the consumer pops in the same cycle.
  assign in_ready  = (level != LW'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Decode at write time: single codes map to one bit, pair codes to two adjacent bits.
  always_comb begin
    dec_bits = 8'h00;
    dec_none = 1'b0;
    if (in_code == 3'd0) begin
      dec_none = 1'b1;
    end else begin
      dec_bits = (in_pair ? 8'h03 : 8'h01) << (in_code - 3'd1);
    end
  end

  // Next-state occupancy and the entry that will sit at the head after this edge.
  always_comb begin
    rd_ptr_n        = pop ? rd_ptr + AW'(1) : rd_ptr;
    level_after_pop = pop ? level - LW'(1) : level;
    level_n         = push ? level_after_pop + LW'(1) : level_after_pop;
    // When the FIFO drains to nothing but the incoming entry, that entry becomes the head.
    if (push && (level_after_pop == '0)) begin
      head_n = {dec_none, dec_bits};
    end else begin
      head_n = mem[rd_ptr_n];
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {dec_none, dec_bits};
    end
  end

  // Pointers, occupancy, registered head output and the code-0 counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      out_bits   <= 8'h00;
      out_none   <= 1'b0;
      none_count <= 8'h00;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      out_bits <= 8'h00;
      out_none <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr_n;
      level  <= level_n;
      // With nothing left the outputs keep the last popped value.
      if (level_n != '0) begin
        out_none <= head_n[8];
        out_bits <= head_n[7:0];
      end
      if (push && dec_none && (none_count != 8'hFF)) begin
        none_count <= none_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/priority_code_decoder.md
# priority_code_decoder

Streaming decoder for the 3-bit priority codes produced by the 8-bit priority encoder. It converts each code back into a minimal 8-bit bit pattern: one-hot for single-bit codes, two-hot for adjacent-pair codes. Codes enter through a valid/ready handshake and are buffered in a small FIFO. The decoded results leave through a second valid/ready handshake, so the block can sit between an encoder stage and a slower consumer.

## Interface
Parameters:
- DEPTH, 2, FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous clear of FIFO contents.
- in_valid  input  1  code offered.
- in_ready  output  1  FIFO can accept.
- in_code  input  3  priority code, n+1 encoded; 0 = no bit.
- in_pair  input  1  0 = single-bit code, 1 = adjacent-pair code.
- out_valid  output  1  decoded entry available.
- out_ready  input  1  consumer accepts.
- out_bits  output  8  decoded pattern.
- out_none  output  1  entry came from code 0.
- none_count  output  8  saturating count of accepted code-0 entries.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Decode happens at write time. Each FIFO entry stores {out_none, out_bits}, 9 bits wide.
- Single-bit mapping (in_pair=0):
  - code 0 → 8'h00, none=1.
  - code k (1..7) → bit k-1 set.
  - code 7 → 8'b0100_0000. Bit 7 is never produced, because the encoder folds bit 7 into code 7; the decoder emits the minimal reconstruction.
- Pair mapping (in_pair=1):
  - code 0 → 8'h00, none=1.
  - code k (1..7) → bits k and k-1 set. Examples: 1 → 8'h03, 2 → 8'h06, 7 → 8'hC0.
- Push: in_valid && in_ready at a rising edge.
- Pop: out_valid && out_ready at a rising edge.
- in_ready = (level != DEPTH). It is registered state only and has no combinational path from out_ready. When full, a same-cycle pop does not enable a push.
- out_valid = (level != 0). out_bits and out_none come from the head entry and are registered. When out_valid=0 they hold the last popped value, or zero after reset or flush.
- Push and pop in the same cycle (not full, not empty): level is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- none_count increments on each push with in_code==0 and saturates at 255. flush does not clear it; only rst does.
- flush:
  - Next edge: level=0 and both pointers=0; out_bits and out_none are zeroed.
  - A push in the same cycle is discarded and does not count toward none_count.
  - flush has priority over push and pop.
- When out_valid=1 and out_ready=0, out_bits and out_none stay stable until the pop.

## Timing
- Reset values (asynchronous, immediate on rst assertion): in_ready=1, out_valid=0, out_bits=0, out_none=0, none_count=0, level=0, pointers=0.
- After rst deasserts, the first push is possible on the next rising edge.
- Latency: a push at edge N makes the entry visible at out_* and sets out_valid after edge N. There is no fall-through within a cycle.
- Throughput: one entry per cycle sustained when out_ready is held high and DEPTH ≥ 2.
- rst mid-stream: all entries are lost immediately. The outputs take their reset values asynchronously, not at the next edge.

## Test plan
- Reset and empty: assert rst, drive in_valid=0 → in_ready=1, out_valid=0, out_bits=0, none_count=0, level=0.
- Full single sweep: push codes 0..7 with in_pair=0 and out_ready=1 → outputs in order:
  - 00 (none=1), 01, 02, 04, 08, 10, 20, 40.
  - none_count=1.
- Pair sweep with backpressure: push pair codes 1, 2, 7 with out_ready=0.
  - After 2 pushes: level=2, in_ready=0, and the third code is held by the source.
  - Then release out_ready → outputs 03, 06, C0 in order, with no loss or duplication.
- Full plus simultaneous pop: with the FIFO full, assert in_valid and out_ready together.
  - That cycle: pop only; level goes 2 → 1.
  - Next cycle: push and pop together; level stays 1.
- Flush with push: with level=2, assert flush together with in_valid and code 0 → level=0, out_valid=0, out_bits=0, none_count unchanged.
- Saturation and async reset:
  - Push 300 code-0 entries with out_ready=1 → none_count=255.
  - Assert rst between clock edges → none_count=0 and out_valid=0 before the next edge.
